// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder at the far end of the pipeline's data-memory
// interface. Stores are committed byte-lane-accurately into an internal word
// array on the rising edge of the request cycle. Loads return the raw aligned
// word one cycle later. Misaligned or illegal accesses are flagged with a
// one-cycle pulse and counted in a saturating counter.
//
// Response semantics: there is no ready/backpressure. Every request is
// accepted in the cycle it is presented. d_read_valid is a one-cycle pulse
// meaning "d_data_read holds the response to the load presented on the
// previous rising edge". d_misaligned pulses in the same way for the
// previous cycle's access.
//
// Parameters:
//   ADDR_WIDTH     word-address bits; the array holds 2**ADDR_WIDTH words
//   CNT_WIDTH      width of the saturating misalign counter
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous, active-low reset
//   d_address      byte address; upper bits above ADDR_WIDTH+1 are ignored
//   d_data_write   store data, already shifted onto its byte lanes
//   d_write_enable store request this cycle
//   d_read_enable  load request this cycle (ignored when storing)
//   d_size         0 = byte, 1 = half, 2 = word, 3 = illegal
//   d_data_read    registered raw word read (0 for a misaligned load)
//   d_read_valid   one-cycle pulse: previous cycle's load response
//   d_misaligned   one-cycle pulse: previous cycle's access was illegal
//   misalign_count saturating count of misaligned/illegal accesses
//   count_clear    synchronous clear of misalign_count (beats an increment)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          d_address,
    input  logic [31:0]          d_data_write,
    input  logic                 d_write_enable,
    input  logic                 d_read_enable,
    input  logic [1:0]           d_size,
    output logic [31:0]          d_data_read,
    output logic                 d_read_valid,
    output logic                 d_misaligned,
    output logic [CNT_WIDTH-1:0] misalign_count,
    input  logic                 count_clear
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Access size encoding on d_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Word array; contents are deliberately not reset.
    logic [31:0] mem_q [DEPTH];

    // Registered outputs and their next-state values
    logic [31:0]          data_read_q,  data_read_d;
    logic                 read_valid_q, read_valid_d;
    logic                 misaligned_q, misaligned_d;
    logic [CNT_WIDTH-1:0] count_q,      count_d;

    // Request decode
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_off;
    logic [3:0]            lane_mask;
    logic                  legal;
    logic                  access;
    logic                  is_load;
    logic                  store_ok;
    logic                  bad_access;

    // Upper address bits are dropped so addresses wrap modulo the array size.
    assign word_idx = d_address[ADDR_WIDTH+1:2];
    assign byte_off = d_address[1:0];

    // Lane mask and legality from the byte offset and access size. A half
    // access at offset 2 uses lanes 2 and 3; at an odd offset it would cross
    // a lane pair and is rejected.
    always_comb begin
        lane_mask = 4'b0000;
        legal     = 1'b0;
        case (d_size)
            SIZE_BYTE: begin
                lane_mask = 4'b0001 << byte_off;
                legal     = 1'b1;
            end
            SIZE_HALF: begin
                lane_mask = 4'b0011 << byte_off;
                legal     = ~byte_off[0];
            end
            SIZE_WORD: begin
                lane_mask = 4'b1111;
                legal     = (byte_off == 2'b00);
            end
            default: begin
                lane_mask = 4'b0000;
                legal     = 1'b0;
            end
        endcase
    end

    // A combined read+write request is a single store; the read is dropped.
    assign access     = d_write_enable | d_read_enable;
    assign is_load    = d_read_enable & ~d_write_enable;
    assign store_ok   = d_write_enable & legal;
    assign bad_access = access & ~legal;

    // Byte-lane store into the array. Lanes outside the mask keep their data.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= d_data_write[8*b +: 8];
                end
            end
        end
    end

    // Next-state for the output registers
    always_comb begin
        data_read_d  = data_read_q;
        read_valid_d = is_load;
        misaligned_d = bad_access;
        count_d      = count_q;

        // A misaligned load still responds, but with zero data.
        if (is_load) begin
            data_read_d = legal ? mem_q[word_idx] : 32'h0000_0000;
        end

        // Clear wins over an increment; the counter sticks at all-ones.
        if (count_clear) begin
            count_d = '0;
        end else if (bad_access && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_read_q  <= 32'h0000_0000;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            data_read_q  <= data_read_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    assign d_data_read    = data_read_q;
    assign d_read_valid   = read_valid_q;
    assign d_misaligned   = misaligned_q;
    assign misalign_count = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic [31:0]   d_address;
    logic [31:0]   d_data_write;
    logic          d_write_enable;
    logic          d_read_enable;
    logic [1:0]    d_size;
    logic [31:0]   d_data_read;
    logic          d_read_valid;
    logic          d_misaligned;
    logic [CW-1:0] misalign_count;
    logic          count_clear;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    dmem_responder #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .d_address     (d_address),
        .d_data_write  (d_data_write),
        .d_write_enable(d_write_enable),
        .d_read_enable (d_read_enable),
        .d_size        (d_size),
        .d_data_read   (d_data_read),
        .d_read_valid  (d_read_valid),
        .d_misaligned  (d_misaligned),
        .misalign_count(misalign_count),
        .count_clear   (count_clear)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // at the same point, i.e. they reflect the access of the previous cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        d_write_enable = 1'b0;
        d_read_enable  = 1'b0;
        count_clear    = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size);
        d_address      = addr;
        d_data_write   = data;
        d_size         = size;
        d_write_enable = 1'b1;
        d_read_enable  = 1'b0;
        step();
        drive_idle();
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size);
        d_address      = addr;
        d_size         = size;
        d_write_enable = 1'b0;
        d_read_enable  = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic do_clear();
        count_clear = 1'b1;
        step();
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        d_address = 32'h0;
        d_data_write = 32'h0;
        d_size = 2'd2;
        drive_idle();
        step();
        step();
        checks++;
        if (d_data_read !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=%h", d_data_read, 32'h0);
        end
        checks++;
        if (d_read_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", d_read_valid);
        end
        checks++;
        if (d_misaligned !== 1'b0) begin
            failures++; $display("FAIL reset_misaligned got=%b exp=0", d_misaligned);
        end
        checks++;
        if (misalign_count !== 4'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", misalign_count);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_word();
        do_store(32'h100, 32'hDEAD_BEEF, 2'd2);
        checks++;
        if (d_read_valid !== 1'b0 || d_misaligned !== 1'b0) begin
            failures++; $display("FAIL word_store_pulses got=%b%b exp=00", d_read_valid, d_misaligned);
        end
        do_load(32'h100, 2'd2);
        checks++;
        if (d_read_valid !== 1'b1) begin
            failures++; $display("FAIL word_load_valid got=%b exp=1", d_read_valid);
        end
        checks++;
        if (d_data_read !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL word_load_data got=%h exp=%h", d_data_read, 32'hDEAD_BEEF);
        end
        checks++;
        if (d_misaligned !== 1'b0) begin
            failures++; $display("FAIL word_load_misaligned got=%b exp=0", d_misaligned);
        end
        step();
        checks++;
        if (d_read_valid !== 1'b0 || d_data_read !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL idle_hold got=%b/%h exp=0/%h", d_read_valid, d_data_read, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_byte_half();
        do_store(32'h100, 32'h1122_3344, 2'd2);
        do_store(32'h102, 32'h00AB_0000, 2'd0);
        do_load(32'h100, 2'd2);
        checks++;
        if (d_data_read !== 32'h11AB_3344 || d_read_valid !== 1'b1) begin
            failures++; $display("FAIL byte_store got=%h exp=%h", d_data_read, 32'h11AB_3344);
        end
        do_store(32'h102, 32'hCAFE_0000, 2'd1);
        do_load(32'h100, 2'd2);
        checks++;
        if (d_data_read !== 32'hCAFE_3344) begin
            failures++; $display("FAIL half_store got=%h exp=%h", d_data_read, 32'hCAFE_3344);
        end
    endtask

    task automatic test_misaligned();
        do_clear();
        do_load(32'h101, 2'd1);
        checks++;
        if (d_read_valid !== 1'b1 || d_data_read !== 32'h0 || d_misaligned !== 1'b1) begin
            failures++; $display("FAIL mis_load got=v%b d%h m%b exp=v1 d0 m1", d_read_valid, d_data_read, d_misaligned);
        end
        do_store(32'h102, 32'hFFFF_FFFF, 2'd2);
        checks++;
        if (d_misaligned !== 1'b1 || d_read_valid !== 1'b0) begin
            failures++; $display("FAIL mis_store got=m%b v%b exp=m1 v0", d_misaligned, d_read_valid);
        end
        do_load(32'h100, 2'd2);
        checks++;
        if (d_data_read !== 32'hCAFE_3344 || d_misaligned !== 1'b0) begin
            failures++; $display("FAIL mis_unchanged got=%h m%b exp=%h m0", d_data_read, d_misaligned, 32'hCAFE_3344);
        end
        checks++;
        if (misalign_count !== 4'd2) begin
            failures++; $display("FAIL mis_count2 got=%0d exp=2", misalign_count);
        end
        do_load(32'h100, 2'd3);
        checks++;
        if (d_misaligned !== 1'b1 || d_data_read !== 32'h0 || misalign_count !== 4'd3) begin
            failures++; $display("FAIL size3 got=m%b d%h c%0d exp=m1 d0 c3", d_misaligned, d_data_read, misalign_count);
        end
    endtask

    task automatic test_alias();
        do_store(32'h0, 32'h0000_0055, 2'd2);
        do_load(32'h1000, 2'd2);
        checks++;
        if (d_data_read !== 32'h0000_0055 || d_read_valid !== 1'b1) begin
            failures++; $display("FAIL alias got=%h exp=%h", d_data_read, 32'h0000_0055);
        end
    endtask

    task automatic test_rw_simul();
        d_address      = 32'h200;
        d_data_write   = 32'h1234_5678;
        d_size         = 2'd2;
        d_write_enable = 1'b1;
        d_read_enable  = 1'b1;
        step();
        drive_idle();
        checks++;
        if (d_read_valid !== 1'b0 || d_misaligned !== 1'b0) begin
            failures++; $display("FAIL rw_no_valid got=v%b m%b exp=v0 m0", d_read_valid, d_misaligned);
        end
        do_load(32'h200, 2'd2);
        checks++;
        if (d_data_read !== 32'h1234_5678 || d_read_valid !== 1'b1) begin
            failures++; $display("FAIL rw_followup got=%h exp=%h", d_data_read, 32'h1234_5678);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        logic [31:0] exp;
        vals[0] = 32'hA5A5_0001;
        vals[1] = 32'h5A5A_0002;
        vals[2] = 32'h0F0F_0003;
        for (int i = 0; i < 3; i++) begin
            do_store(32'h300 + 32'(4 * i), vals[i], 2'd2);
            exp_q.push_back(vals[i]);
        end
        // Loads issued on consecutive cycles without idle gaps
        for (int i = 0; i < 3; i++) begin
            d_address     = 32'h300 + 32'(4 * i);
            d_size        = 2'd2;
            d_read_enable = 1'b1;
            step();
            exp = exp_q.pop_front();
            checks++;
            if (d_read_valid !== 1'b1 || d_data_read !== exp) begin
                failures++; $display("FAIL b2b_%0d got=v%b %h exp=v1 %h", i, d_read_valid, d_data_read, exp);
            end
        end
        drive_idle();
        step();
        checks++;
        if (d_read_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_end got=%b exp=0", d_read_valid);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        for (int i = 0; i < 17; i++) begin
            do_load(32'h3, 2'd2);
        end
        checks++;
        if (misalign_count !== 4'hF) begin
            failures++; $display("FAIL saturate got=%0d exp=15", misalign_count);
        end
        d_address     = 32'h1;
        d_size        = 2'd1;
        d_read_enable = 1'b1;
        count_clear   = 1'b1;
        step();
        drive_idle();
        checks++;
        if (misalign_count !== 4'd0 || d_misaligned !== 1'b1) begin
            failures++; $display("FAIL clear_prio got=c%0d m%b exp=c0 m1", misalign_count, d_misaligned);
        end
    endtask

    task automatic test_reset_mid();
        do_load(32'h303, 2'd2);
        do_load(32'h304, 2'd2);
        // Present a load, then assert reset part-way through the cycle.
        d_address     = 32'h300;
        d_size        = 2'd2;
        d_read_enable = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (d_read_valid !== 1'b0 || d_data_read !== 32'h0 || d_misaligned !== 1'b0 || misalign_count !== 4'd0) begin
            failures++; $display("FAIL reset_async got=v%b d%h m%b c%0d exp=all0", d_read_valid, d_data_read, d_misaligned, misalign_count);
        end
        step();
        checks++;
        if (d_read_valid !== 1'b0 || d_data_read !== 32'h0) begin
            failures++; $display("FAIL reset_hold got=v%b d%h exp=v0 d0", d_read_valid, d_data_read);
        end
        drive_idle();
        reset_n = 1'b1;
        step();
        checks++;
        if (d_read_valid !== 1'b0 || misalign_count !== 4'd0) begin
            failures++; $display("FAIL reset_release got=v%b c%0d exp=v0 c0", d_read_valid, misalign_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_alias();
        test_rw_simul();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
